decode_scoreboard: RTL and testbench
====================================

# decode_scoreboard

Register-dependency scoreboard that controls the decode stage. It tracks in-flight writes to each architectural register and holds the instruction in decode while its sources, or its destination, are unsafe. An instruction issues into execute only when the scoreboard, the downstream stage and flush all permit it. It sits beside the decode datapath, between the fetch→decode pipeline register and execute, and receives retire information from writeback.

## Interface
- NREG, 32: number of architectural registers; x0 is never tracked.
- CNT_W, 2: width of each per-register in-flight counter; maximum count is 2^CNT_W−1 (3).
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- id_valid  in  1  a decoded instruction is present in decode.
- id_ra1, id_ra2  in  creg_addr_t  source register addresses; these are the same values driven to the register file.
- id_use1, id_use2  in  1  the matching source is actually read.
- id_wen  in  1  the instruction writes a register.
- id_dst  in  creg_addr_t  destination register (raw_instr[11:7]).
- id_fence  in  1  the instruction must wait until no register writes are in flight.
- ex_ready  in  1  execute can accept an instruction this cycle.
- flush  in  1  kill the decode-stage instruction this cycle.
- wb_valid, wb_wen  in  1  writeback retires an instruction that wrote a register.
- wb_dst  in  creg_addr_t  retired destination register.
- id_ready  out  1  decode may hand its instruction to execute; when low, fetch and decode hold.
- issue  out  1  the instruction issues this cycle.
- busy  out  1  at least one counter is nonzero.
- pending  out  NREG  per-register flag, set when that register's counter is nonzero.
- err  out  1  sticky flag for a retire to a register whose counter is zero.
- stall_cnt  out  32  count of cycles in which id_valid was high and id_ready was low.

## Operation
- Stall condition (combinational, from current counters):
  - hazard = (id_use1 & ra1≠0 & cnt[ra1]≠0) | (id_use2 & ra2≠0 & cnt[ra2]≠0) | (id_wen & dst≠0 & cnt[dst]==MAX) | (id_fence & busy).
- id_ready = ~hazard & ex_ready.
- issue = id_valid & id_ready & ~flush.
- inc = issue & id_wen & id_dst≠0: increments cnt[id_dst].
- dec = wb_valid & wb_wen & wb_dst≠0: decrements cnt[wb_dst].
- inc and dec on the same register in the same cycle leave the counter unchanged. On different registers, both updates apply.
- dec on a zero counter: the counter stays 0 and err is set. err holds until reset.
- inc never exceeds MAX, because the destination-saturation term stalls decode first.
- flush blocks issue only. Counters of instructions already issued are kept, because those instructions are older than the flush and always reach writeback.
- stall_cnt increments when id_valid & ~id_ready & ~flush. It wraps modulo 2^32.
- Writes to x0 and reads of x0 never cause a stall.

## Timing
- Reset (asynchronous, resetn=0): all counters 0, err 0, stall_cnt 0.
  - While resetn=0: busy 0, pending 0, id_ready equals ex_ready (no hazard possible), issue equals id_valid & ex_ready & ~flush.
- id_ready and issue are combinational in the same cycle. There is no registered latency on the stall path.
- Counter updates take effect at the next rising edge. A retire in cycle t releases a dependent stall in cycle t+1; there is no same-cycle bypass.
- An instruction issued in cycle t that writes rd makes a reader of rd stall from cycle t+1 onward.
- Fence: id_ready stays low while busy. The fence issues in the first cycle where busy=0 and ex_ready=1.
- resetn asserted mid-operation clears all in-flight tracking immediately. The pipeline is reset at the same time.

## Structure
- Shared package (pipes): scoreboard_cnt_t (logic[CNT_W-1:0]), constant SB_CNT_MAX.
- Shared package (common): creg_addr_t, which already exists.
- One natural sub-module, sb_counter: a single saturating up/down counter with inc, dec, zero and full outputs, and an underflow flag. It is instantiated NREG−1 times by a generate loop (x0 excluded).
- The hazard logic and the perf counter live in the top module.

## Test plan
- Back-to-back RAW:
  - Stimulus: issue add x5 (wen, dst=5), then an instruction reading ra1=5.
  - Required: second instruction id_ready=0 until wb retires x5 at cycle t; id_ready=1 at t+1.
  - Required: stall_cnt equals the number of stalled cycles.
- Saturation:
  - Stimulus: issue three writes to x7 with no retire; a fourth write to x7 is presented.
  - Required: fourth write stalls.
  - Stimulus: one retire of x7.
  - Required: fourth write issues the next cycle; pending[7]=1 throughout.
- Simultaneous inc and dec:
  - Stimulus: cnt[3]=1; issue a write to x3 and retire x3 in the same cycle.
  - Required: cnt[3] stays 1; pending[3]=1.
- x0 and flush:
  - Stimulus: a write to x0 issues.
  - Required: pending stays 0.
  - Stimulus: a write to x9 with flush=1 and ex_ready=1.
  - Required: issue=0 and pending[9]=0.
- Fence and underflow:
  - Stimulus: two writes in flight, then id_fence.
  - Required: stall until busy=0.
  - Stimulus: retire x12 when cnt[12]=0.
  - Required: err=1 and stays 1; the counter stays 0.
- Async reset:
  - Stimulus: resetn pulsed low between clock edges with counters nonzero.
  - Required: pending=0, busy=0, stall_cnt=0 before the next clock edge.

Source files
------------

// File: rtl/decode_scoreboard_pkg.sv
// Shared types and constants for the decode-stage register scoreboard.
package decode_scoreboard_pkg;

    localparam int unsigned NREG    = 32;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned CREG_AW = $clog2(NREG);

    typedef logic [CREG_AW-1:0] creg_addr_t;
    typedef logic [CNT_W-1:0]   scoreboard_cnt_t;

    localparam scoreboard_cnt_t SB_CNT_MAX = '1;

    // One-hot select of an architectural register; x0 is never tracked.
    function automatic logic [NREG-1:0] reg_onehot(input creg_addr_t a);
        logic [NREG-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        v[0] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/decode_scoreboard_sb_counter.sv
// Saturating up/down counter tracking in-flight writes to one register.
module sb_counter
    import decode_scoreboard_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_zero,
    output logic o_full,
    output logic o_underflow
);

    scoreboard_cnt_t r_cnt;
    logic            w_zero;
    logic            w_full;

    assign w_zero = (r_cnt == '0);
    assign w_full = (r_cnt == SB_CNT_MAX);

    // Count issues up and retires down; simultaneous inc and dec cancel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && !w_full) begin
            r_cnt <= r_cnt + scoreboard_cnt_t'(1);
        end else if (i_dec && !i_inc && !w_zero) begin
            r_cnt <= r_cnt - scoreboard_cnt_t'(1);
        end
    end

    assign o_zero      = w_zero;
    assign o_full      = w_full;
    // A retire with nothing in flight has no matching issue, even if an
    // issue to the same register lands in the same cycle.
    assign o_underflow = i_dec && w_zero;

endmodule

// File: rtl/decode_scoreboard.sv
// Register-dependency scoreboard gating issue from decode into execute.
module decode_scoreboard
    import decode_scoreboard_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            id_valid,
    input  creg_addr_t      id_ra1,
    input  creg_addr_t      id_ra2,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic            id_wen,
    input  creg_addr_t      id_dst,
    input  logic            id_fence,
    input  logic            ex_ready,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic            wb_wen,
    input  creg_addr_t      wb_dst,
    output logic            id_ready,
    output logic            issue,
    output logic            busy,
    output logic [NREG-1:0] pending,
    output logic            err,
    output logic [31:0]     stall_cnt
);

    logic [NREG-1:0] w_zero;
    logic [NREG-1:0] w_full;
    logic [NREG-1:0] w_uflow;
    logic [NREG-1:0] w_inc_vec;
    logic [NREG-1:0] w_dec_vec;
    logic [NREG-1:0] w_pending;
    logic            w_busy;
    logic            w_hazard;
    logic            w_id_ready;
    logic            w_issue;
    logic            w_inc;
    logic            w_dec;
    logic            w_stall;
    logic            r_err;
    logic [31:0]     r_stall_cnt;

    // x0 has no counter: always empty, never full, never underflows.
    assign w_zero[0]  = 1'b1;
    assign w_full[0]  = 1'b0;
    assign w_uflow[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        sb_counter u_cnt (
            .i_clk       (clk),
            .i_rst_n     (resetn),
            .i_inc       (w_inc_vec[g]),
            .i_dec       (w_dec_vec[g]),
            .o_zero      (w_zero[g]),
            .o_full      (w_full[g]),
            .o_underflow (w_uflow[g])
        );
    end

    assign w_pending = ~w_zero;
    assign w_busy    = |w_pending;

    // Stall decision from current counters only; no retire bypass.
    always_comb begin
        w_hazard = 1'b0;
        if (id_use1 && (id_ra1 != '0) && w_pending[id_ra1]) w_hazard = 1'b1;
        if (id_use2 && (id_ra2 != '0) && w_pending[id_ra2]) w_hazard = 1'b1;
        if (id_wen  && (id_dst != '0) && w_full[id_dst])    w_hazard = 1'b1;
        if (id_fence && w_busy)                             w_hazard = 1'b1;
    end

    assign w_id_ready = !w_hazard && ex_ready;
    assign w_issue    = id_valid && w_id_ready && !flush;
    assign w_inc      = w_issue && id_wen;
    assign w_dec      = wb_valid && wb_wen;
    assign w_inc_vec  = w_inc ? reg_onehot(id_dst) : '0;
    assign w_dec_vec  = w_dec ? reg_onehot(wb_dst) : '0;
    assign w_stall    = id_valid && !w_id_ready && !flush;

    // Sticky error for any retire of a register with nothing in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (|w_uflow) begin
            r_err <= 1'b1;
        end
    end

    // Free-running count of scoreboard/downstream stall cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign id_ready  = w_id_ready;
    assign issue     = w_issue;
    assign busy      = w_busy;
    assign pending   = w_pending;
    assign err       = r_err;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard: directed scenarios plus
// randomized traffic against a per-register in-flight count model.
module tb_decode_scoreboard;
    import decode_scoreboard_pkg::*;

    logic            clk;
    logic            resetn;
    logic            id_valid;
    creg_addr_t      id_ra1;
    creg_addr_t      id_ra2;
    logic            id_use1;
    logic            id_use2;
    logic            id_wen;
    creg_addr_t      id_dst;
    logic            id_fence;
    logic            ex_ready;
    logic            flush;
    logic            wb_valid;
    logic            wb_wen;
    creg_addr_t      wb_dst;
    logic            id_ready;
    logic            issue;
    logic            busy;
    logic [NREG-1:0] pending;
    logic            err;
    logic [31:0]     stall_cnt;

    int          n_checks;
    int          n_fail;
    int          m_cnt [NREG];
    bit          m_err;
    logic [31:0] m_stall;

    decode_scoreboard dut (
        .clk       (clk),
        .resetn    (resetn),
        .id_valid  (id_valid),
        .id_ra1    (id_ra1),
        .id_ra2    (id_ra2),
        .id_use1   (id_use1),
        .id_use2   (id_use2),
        .id_wen    (id_wen),
        .id_dst    (id_dst),
        .id_fence  (id_fence),
        .ex_ready  (ex_ready),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_wen    (wb_wen),
        .wb_dst    (wb_dst),
        .id_ready  (id_ready),
        .issue     (issue),
        .busy      (busy),
        .pending   (pending),
        .err       (err),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_busy();
        for (int i = 1; i < NREG; i++) if (m_cnt[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NREG-1:0] m_pending();
        logic [NREG-1:0] v = '0;
        for (int i = 1; i < NREG; i++) v[i] = (m_cnt[i] != 0);
        return v;
    endfunction

    function automatic bit m_hazard();
        bit h = 1'b0;
        if (id_use1 && id_ra1 != 0 && m_cnt[id_ra1] != 0) h = 1'b1;
        if (id_use2 && id_ra2 != 0 && m_cnt[id_ra2] != 0) h = 1'b1;
        if (id_wen && id_dst != 0 && m_cnt[id_dst] == 3) h = 1'b1;
        if (id_fence && m_busy()) h = 1'b1;
        return h;
    endfunction

    function automatic bit m_ready();
        return !m_hazard() && ex_ready;
    endfunction

    function automatic bit m_issue();
        return id_valid && m_ready() && !flush;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        m_err   = 1'b0;
        m_stall = '0;
    endfunction

    // Apply one clock edge worth of issue/retire to the reference counts.
    function automatic void m_step();
        bit inc;
        bit dec;
        inc = m_issue() && id_wen && id_dst != 0;
        dec = wb_valid && wb_wen && wb_dst != 0;
        if (id_valid && !m_ready() && !flush) m_stall = m_stall + 1;
        if (dec && m_cnt[wb_dst] == 0) m_err = 1'b1;
        if (inc && dec && id_dst == wb_dst) begin
            // net zero change
        end else begin
            if (dec && m_cnt[wb_dst] > 0) m_cnt[wb_dst] = m_cnt[wb_dst] - 1;
            if (inc) m_cnt[id_dst] = m_cnt[id_dst] + 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (resetn) m_step();
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_ra1 = '0; id_ra2 = '0; id_use1 = 0; id_use2 = 0;
        id_wen = 0; id_dst = '0; id_fence = 0; ex_ready = 1; flush = 0;
        wb_valid = 0; wb_wen = 0; wb_dst = '0;
    endtask

    task automatic set_write(input int rd);
        idle();
        id_valid = 1; id_wen = 1; id_dst = creg_addr_t'(rd);
    endtask

    task automatic set_retire(input int rd);
        wb_valid = 1; wb_wen = 1; wb_dst = creg_addr_t'(rd);
    endtask

    task automatic test_reset();
        resetn = 0;
        idle();
        id_valid = 1; id_use1 = 1; id_ra1 = 5'd5; id_wen = 1; id_dst = 5'd6;
        m_clear();
        #1;
        n_checks++;
        if (busy !== 1'b0 || pending !== '0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b pending=%h required 0/0", busy, pending);
        end
        n_checks++;
        if (id_ready !== 1'b1 || issue !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: id_ready=%b issue=%b required 1/1", id_ready, issue);
        end
        ex_ready = 0;
        #1;
        n_checks++;
        if (id_ready !== 1'b0 || issue !== 1'b0) begin
            n_fail++; $display("FAIL reset_exready: id_ready=%b issue=%b required 0/0", id_ready, issue);
        end
        tick();
        n_checks++;
        if (stall_cnt !== 32'd0 || err !== 1'b0 || pending !== '0) begin
            n_fail++; $display("FAIL reset_hold: stall_cnt=%0d err=%b pending=%h required 0/0/0", stall_cnt, err, pending);
        end
        idle();
        #2 resetn = 1;
        #1;
    endtask

    task automatic test_raw();
        logic [31:0] s0;
        set_write(5);
        #1;
        n_checks++;
        if (issue !== 1'b1) begin
            n_fail++; $display("FAIL raw_issue_writer: issue=%b required 1", issue);
        end
        tick();
        s0 = stall_cnt;
        idle();
        id_valid = 1; id_use1 = 1; id_ra1 = 5'd5;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (id_ready !== 1'b0 || issue !== 1'b0 || pending[5] !== 1'b1) begin
                n_fail++; $display("FAIL raw_stall: cycle %0d id_ready=%b issue=%b pending5=%b required 0/0/1", c, id_ready, issue, pending[5]);
            end
            tick();
        end
        set_retire(5);
        #1;
        n_checks++;
        if (id_ready !== 1'b0) begin
            n_fail++; $display("FAIL raw_no_bypass: id_ready=%b required 0", id_ready);
        end
        tick();
        wb_valid = 0; wb_wen = 0;
        #1;
        n_checks++;
        if (id_ready !== 1'b1 || issue !== 1'b1 || pending !== '0) begin
            n_fail++; $display("FAIL raw_release: id_ready=%b issue=%b pending=%h required 1/1/0", id_ready, issue, pending);
        end
        n_checks++;
        if (stall_cnt - s0 !== 32'd4 || stall_cnt !== m_stall) begin
            n_fail++; $display("FAIL raw_stall_cnt: stall_cnt=%0d (base %0d) required base+4=%0d", stall_cnt, s0, m_stall);
        end
        tick();
        idle();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            set_write(7);
            #1;
            n_checks++;
            if (issue !== 1'b1) begin
                n_fail++; $display("FAIL sat_fill: write %0d issue=%b required 1", k, issue);
            end
            tick();
        end
        set_write(7);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (id_ready !== 1'b0 || issue !== 1'b0 || pending[7] !== 1'b1) begin
                n_fail++; $display("FAIL sat_stall: id_ready=%b issue=%b pending7=%b required 0/0/1", id_ready, issue, pending[7]);
            end
            tick();
        end
        set_retire(7);
        #1;
        n_checks++;
        if (id_ready !== 1'b0) begin
            n_fail++; $display("FAIL sat_retire_cycle: id_ready=%b required 0", id_ready);
        end
        tick();
        wb_valid = 0; wb_wen = 0;
        #1;
        n_checks++;
        if (issue !== 1'b1 || pending[7] !== 1'b1) begin
            n_fail++; $display("FAIL sat_release: issue=%b pending7=%b required 1/1", issue, pending[7]);
        end
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            set_retire(7);
            #1;
            n_checks++;
            if (pending[7] !== 1'b1) begin
                n_fail++; $display("FAIL sat_drain: retire %0d pending7=%b required 1", k, pending[7]);
            end
            tick();
        end
        idle();
        #1;
        n_checks++;
        if (pending !== '0 || err !== 1'b0) begin
            n_fail++; $display("FAIL sat_empty: pending=%h err=%b required 0/0", pending, err);
        end
    endtask

    task automatic test_simul();
        set_write(3);
        tick();
        set_write(3);
        set_retire(3);
        #1;
        n_checks++;
        if (issue !== 1'b1) begin
            n_fail++; $display("FAIL simul_issue: issue=%b required 1", issue);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (pending[3] !== 1'b1) begin
            n_fail++; $display("FAIL simul_hold: pending3=%b required 1", pending[3]);
        end
        set_retire(3);
        tick();
        idle();
        #1;
        n_checks++;
        if (pending[3] !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL simul_count_one: pending3=%b err=%b required 0/0", pending[3], err);
        end
    endtask

    task automatic test_x0_flush();
        logic [31:0] s0;
        set_write(0);
        #1;
        n_checks++;
        if (issue !== 1'b1) begin
            n_fail++; $display("FAIL x0_issue: issue=%b required 1", issue);
        end
        tick();
        idle();
        id_valid = 1; id_use1 = 1; id_use2 = 1;
        #1;
        n_checks++;
        if (pending !== '0 || busy !== 1'b0 || id_ready !== 1'b1) begin
            n_fail++; $display("FAIL x0_untracked: pending=%h busy=%b id_ready=%b required 0/0/1", pending, busy, id_ready);
        end
        set_write(9);
        flush = 1;
        s0 = stall_cnt;
        #1;
        n_checks++;
        if (issue !== 1'b0 || id_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_issue: issue=%b id_ready=%b required 0/1", issue, id_ready);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (pending[9] !== 1'b0 || stall_cnt !== s0) begin
            n_fail++; $display("FAIL flush_pending: pending9=%b stall_cnt=%0d required 0/%0d", pending[9], stall_cnt, s0);
        end
    endtask

    task automatic test_fence_underflow();
        set_write(10); tick();
        set_write(11); tick();
        idle();
        id_valid = 1; id_fence = 1;
        #1;
        n_checks++;
        if (id_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL fence_stall: id_ready=%b busy=%b required 0/1", id_ready, busy);
        end
        set_retire(10);
        tick();
        #1;
        n_checks++;
        if (id_ready !== 1'b0) begin
            n_fail++; $display("FAIL fence_partial: id_ready=%b required 0", id_ready);
        end
        set_retire(11);
        tick();
        wb_valid = 0; wb_wen = 0;
        ex_ready = 0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || id_ready !== 1'b0) begin
            n_fail++; $display("FAIL fence_exready: busy=%b id_ready=%b required 0/0", busy, id_ready);
        end
        tick();
        ex_ready = 1;
        #1;
        n_checks++;
        if (id_ready !== 1'b1 || issue !== 1'b1) begin
            n_fail++; $display("FAIL fence_go: id_ready=%b issue=%b required 1/1", id_ready, issue);
        end
        tick();
        idle();
        set_retire(12);
        #1;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL uflow_pre: err=%b required 0", err);
        end
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (err !== 1'b1 || pending[12] !== 1'b0) begin
                n_fail++; $display("FAIL uflow_sticky: cycle %0d err=%b pending12=%b required 1/0", c, err, pending[12]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int cand [$];
        for (int c = 0; c < 400; c++) begin
            idle();
            id_valid = ($urandom_range(0, 9) < 8);
            id_ra1   = creg_addr_t'($urandom_range(0, 7));
            id_ra2   = creg_addr_t'($urandom_range(0, 7));
            id_use1  = $urandom_range(0, 1);
            id_use2  = $urandom_range(0, 1);
            id_wen   = ($urandom_range(0, 3) != 0);
            id_dst   = creg_addr_t'($urandom_range(0, 7));
            id_fence = ($urandom_range(0, 15) == 0);
            ex_ready = ($urandom_range(0, 7) != 0);
            flush    = ($urandom_range(0, 11) == 0);
            cand.delete();
            for (int i = 1; i < NREG; i++) if (m_cnt[i] != 0) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 9) < 6)
                set_retire(cand[$urandom_range(0, cand.size() - 1)]);
            #1;
            n_checks++;
            if (id_ready !== m_ready() || issue !== m_issue() || busy !== m_busy()) begin
                n_fail++; $display("FAIL rand_ctrl: cycle %0d id_ready=%b issue=%b busy=%b required %b/%b/%b", c, id_ready, issue, busy, m_ready(), m_issue(), m_busy());
            end
            n_checks++;
            if (pending !== m_pending() || err !== m_err || stall_cnt !== m_stall) begin
                n_fail++; $display("FAIL rand_state: cycle %0d pending=%h err=%b stall_cnt=%0d required %h/%b/%0d", c, pending, err, stall_cnt, m_pending(), m_err, m_stall);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        set_write(4); tick();
        set_write(8); tick();
        idle();
        id_valid = 1; id_use1 = 1; id_ra1 = 5'd4;
        tick();
        #1;
        n_checks++;
        if (pending[4] !== 1'b1 || stall_cnt === 32'd0) begin
            n_fail++; $display("FAIL areset_pre: pending4=%b stall_cnt=%0d required 1/nonzero", pending[4], stall_cnt);
        end
        resetn = 0;
        m_clear();
        #1;
        n_checks++;
        if (pending !== '0 || busy !== 1'b0 || stall_cnt !== 32'd0 || err !== 1'b0) begin
            n_fail++; $display("FAIL areset_clear: pending=%h busy=%b stall_cnt=%0d err=%b required 0/0/0/0", pending, busy, stall_cnt, err);
        end
        n_checks++;
        if (id_ready !== 1'b1 || issue !== 1'b1) begin
            n_fail++; $display("FAIL areset_ready: id_ready=%b issue=%b required 1/1", id_ready, issue);
        end
        #1 resetn = 1;
        idle();
        tick();
        #1;
        n_checks++;
        if (pending !== '0 || stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL areset_after: pending=%h stall_cnt=%0d required 0/0", pending, stall_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_raw();
        test_saturation();
        test_simul();
        test_x0_flush();
        test_fence_underflow();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
